// File: rtl/vector_cache_pkg.sv
// Shared types for the vector cache write-data path.
//   group_data_pld_t : one beat of group data travelling toward a data-RAM channel
//   wdb_entry_t      : one buffered write beat, channel select plus payload
package vector_cache_pkg;

  typedef logic [31:0] group_data_pld_t;

  typedef struct packed {
    logic            ch_sel;  // 0 -> even channel of the hash, 1 -> odd channel
    group_data_pld_t pld;
  } wdb_entry_t;

endpackage

// File: rtl/wdb_data_dispatch_if.sv
// Bundle between the write data buffer, the dispatch block and the data-RAM channels.
//   wdb_data_in_vld/_in/_in_ch_sel/_in_rdy : per-hash beat stream from the write data buffer
//   data_in_vld_todb/_todb/_rdy_fromdb     : per-channel beat stream toward the data RAM
//   dispatch_idle                          : all hash buffers empty
// modport slave is the dispatch block; modport master is its environment.
interface wdb_data_dispatch_if
  import vector_cache_pkg::*;
#(
  parameter int NUM_HASH = 4
);

  logic [NUM_HASH-1:0]   wdb_data_in_vld;
  group_data_pld_t       wdb_data_in [NUM_HASH];
  logic [NUM_HASH-1:0]   wdb_data_in_ch_sel;
  logic [NUM_HASH-1:0]   wdb_data_in_rdy;
  logic [2*NUM_HASH-1:0] data_in_vld_todb;
  group_data_pld_t       data_in_todb [2*NUM_HASH];
  logic [2*NUM_HASH-1:0] data_in_rdy_fromdb;
  logic                  dispatch_idle;

  modport master (
    output wdb_data_in_vld, wdb_data_in, wdb_data_in_ch_sel, data_in_rdy_fromdb,
    input  wdb_data_in_rdy, data_in_vld_todb, data_in_todb, dispatch_idle
  );

  modport slave (
    input  wdb_data_in_vld, wdb_data_in, wdb_data_in_ch_sel, data_in_rdy_fromdb,
    output wdb_data_in_rdy, data_in_vld_todb, data_in_todb, dispatch_idle
  );

endinterface

// File: rtl/wdb_hash_fifo.sv
// One hash group's write-beat FIFO with a registered input ready, and head decode onto the
// two data-RAM channels owned by the hash.
//   clk, rst    : clock, asynchronous active-high reset
//   in_vld/in_pld/in_ch_sel/in_rdy : incoming beat stream (in_rdy is a flop)
//   out_vld[1:0]: valid toward channel 2i (bit 0) and 2i+1 (bit 1); never both set
//   out_pld     : head payload, shared by both channels
//   out_rdy[1:0]: channel readies; only the selected channel's ready can pop
//   empty_next  : FIFO will be empty after this edge (feeds the idle flop)
module wdb_hash_fifo
  import vector_cache_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  group_data_pld_t in_pld,
  input  logic            in_ch_sel,
  output logic            in_rdy,
  output logic [1:0]      out_vld,
  output group_data_pld_t out_pld,
  input  logic [1:0]      out_rdy,
  output logic            empty_next
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  wdb_entry_t       mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] prev_ptr;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             rdy_reg;
  logic             push, pop, nonempty;
  wdb_entry_t       head;

  assign push     = in_vld & rdy_reg;
  assign nonempty = (count_reg != '0);
  assign head     = mem_reg[rd_ptr_reg];

  // The select bit picks exactly one of the pair, so the two channels can never be valid together.
  assign out_vld  = {nonempty & head.ch_sel, nonempty & ~head.ch_sel};
  assign pop      = |(out_vld & out_rdy);

  // When empty, present the entry that was the head last, so the payload never goes undefined.
  assign prev_ptr = (rd_ptr_reg == '0) ? LAST_PTR : rd_ptr_reg - 1'b1;
  assign out_pld  = nonempty ? head.pld : mem_reg[prev_ptr].pld;

  assign in_rdy     = rdy_reg;
  assign empty_next = (count_next == '0);

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (push) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rdy_reg    <= 1'b0;
      for (int e = 0; e < FIFO_DEPTH; e++) mem_reg[e] <= '0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      // Ready looks only at the next occupancy, which keeps channel readies off the input ready
      // path; a full FIFO therefore refuses a beat even in a cycle where it pops.
      rdy_reg    <= (count_next < DEPTH_C);
      if (push) mem_reg[wr_ptr_reg] <= {in_ch_sel, in_pld};
    end
  end

  a_one_channel: assert property (@(posedge clk) disable iff (rst) !(out_vld[0] && out_vld[1]));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count_reg == DEPTH_C));
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_reg <= DEPTH_C);

endmodule

// File: rtl/wdb_data_dispatch.sv
// Steers per-hash write beats from the write data buffer onto the two data-RAM channels of each
// hash (2i or 2i+1, picked per beat), buffering each hash independently.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wdb_data_dispatch_if.slave carrying the per-hash input streams, the per-channel
//              output streams and dispatch_idle (registered: all hash FIFOs empty)
module wdb_data_dispatch
  import vector_cache_pkg::*;
#(
  parameter int NUM_HASH   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  wdb_data_dispatch_if.slave    bus
);

  group_data_pld_t     head_pld [NUM_HASH];
  logic [NUM_HASH-1:0] empty_next;
  logic                idle_reg;

  for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_hash
    wdb_hash_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .in_vld     (bus.wdb_data_in_vld[gi]),
      .in_pld     (bus.wdb_data_in[gi]),
      .in_ch_sel  (bus.wdb_data_in_ch_sel[gi]),
      .in_rdy     (bus.wdb_data_in_rdy[gi]),
      .out_vld    (bus.data_in_vld_todb[2*gi +: 2]),
      .out_pld    (head_pld[gi]),
      .out_rdy    (bus.data_in_rdy_fromdb[2*gi +: 2]),
      .empty_next (empty_next[gi])
    );

    assign bus.data_in_todb[2*gi]     = head_pld[gi];
    assign bus.data_in_todb[2*gi + 1] = head_pld[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_reg <= 1'b1;
    else     idle_reg <= &empty_next;
  end

  assign bus.dispatch_idle = idle_reg;

endmodule

// File: tb/tb_wdb_data_dispatch.sv
// Directed bench for wdb_data_dispatch: reset, single beat, HOL/backpressure, streaming,
// full-FIFO push+pop, and reset with buffered beats.
module tb_wdb_data_dispatch;
  import vector_cache_pkg::*;

  localparam int NH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wdb_data_dispatch_if #(.NUM_HASH(NH)) bus ();

  wdb_data_dispatch #(
    .NUM_HASH  (NH),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic group_data_pld_t pld_of(input int h, input int k);
    return 32'hC000_0000 + 32'(h * 256 + k);
  endfunction

  task automatic clear_inputs();
    bus.wdb_data_in_vld    = '0;
    bus.wdb_data_in_ch_sel = '0;
    for (int h = 0; h < NH; h++) bus.wdb_data_in[h] = '0;
  endtask

  int         exp_idx [NH];
  int         beats_out;
  logic [1:0] pair;
  logic       exp_sel;
  int         hh;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();
    bus.data_in_rdy_fromdb = '0;

    // 1. reset release
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", 64'(bus.wdb_data_in_rdy), 64'h0);
    check("rst_vld", 64'(bus.data_in_vld_todb), 64'h0);
    check("rst_idle", 64'(bus.dispatch_idle), 64'h1);
    check("rst_pld", 64'(bus.data_in_todb[3]), 64'h0);
    rst = 1'b0;
    check("rdy_before_edge", 64'(bus.wdb_data_in_rdy), 64'h0);
    @(negedge clk);
    check("rdy_after_release", 64'(bus.wdb_data_in_rdy), 64'hF);
    check("idle_after_release", 64'(bus.dispatch_idle), 64'h1);
    $display("txn reset release done");

    // 2. single beat on hash 1, channel 3
    bus.data_in_rdy_fromdb    = 8'b0000_1000;
    bus.wdb_data_in_vld[1]    = 1'b1;
    bus.wdb_data_in_ch_sel[1] = 1'b1;
    bus.wdb_data_in[1]        = 32'hA5;
    @(negedge clk);
    clear_inputs();
    check("t2_vld", 64'(bus.data_in_vld_todb), 64'h08);
    check("t2_pld3", 64'(bus.data_in_todb[3]), 64'hA5);
    check("t2_pld2", 64'(bus.data_in_todb[2]), 64'hA5);
    check("t2_idle_busy", 64'(bus.dispatch_idle), 64'h0);
    @(negedge clk);
    check("t2_vld_popped", 64'(bus.data_in_vld_todb), 64'h0);
    check("t2_idle", 64'(bus.dispatch_idle), 64'h1);
    $display("txn hash1 ch3 beat a5");

    // 3. hash 0, three beats (sel 0,1,0) with channel 0 stalled
    bus.data_in_rdy_fromdb    = '0;
    bus.wdb_data_in_vld[0]    = 1'b1;
    bus.wdb_data_in_ch_sel[0] = 1'b0;
    bus.wdb_data_in[0]        = 32'h10;
    @(negedge clk);
    check("t3_rdy_1st", 64'(bus.wdb_data_in_rdy[0]), 64'h1);
    bus.wdb_data_in_ch_sel[0] = 1'b1;
    bus.wdb_data_in[0]        = 32'h11;
    @(negedge clk);
    check("t3_rdy_full", 64'(bus.wdb_data_in_rdy[0]), 64'h0);
    bus.wdb_data_in_ch_sel[0] = 1'b0;
    bus.wdb_data_in[0]        = 32'h12;
    @(negedge clk);
    check("t3_rdy_held", 64'(bus.wdb_data_in_rdy[0]), 64'h0);
    check("t3_vld_ch0", 64'(bus.data_in_vld_todb[1:0]), 64'h1);
    check("t3_pld_ch0", 64'(bus.data_in_todb[0]), 64'h10);
    bus.data_in_rdy_fromdb[1:0] = 2'b11;
    @(negedge clk);
    $display("txn hash0 ch0 beat 10");
    check("t3_vld_ch1", 64'(bus.data_in_vld_todb[1:0]), 64'h2);
    check("t3_pld_ch1", 64'(bus.data_in_todb[1]), 64'h11);
    check("t3_rdy_back", 64'(bus.wdb_data_in_rdy[0]), 64'h1);
    @(negedge clk);
    $display("txn hash0 ch1 beat 11");
    clear_inputs();
    check("t3_vld_ch0b", 64'(bus.data_in_vld_todb[1:0]), 64'h1);
    check("t3_pld_ch0b", 64'(bus.data_in_todb[0]), 64'h12);
    @(negedge clk);
    $display("txn hash0 ch0 beat 12");
    check("t3_drained", 64'(bus.data_in_vld_todb), 64'h0);

    // 4. streaming, all hashes, all channels ready
    bus.data_in_rdy_fromdb = '1;
    beats_out = 0;
    for (int h = 0; h < NH; h++) exp_idx[h] = 0;
    for (int c = 0; c < 20; c++) begin
      for (int h = 0; h < NH; h++) begin
        pair = bus.data_in_vld_todb[2*h +: 2];
        if (pair != 2'b00) begin
          hh      = h;
          exp_sel = exp_idx[h][0] ^ hh[0];
          check("stream_vld", 64'(pair), exp_sel ? 64'h2 : 64'h1);
          check("stream_pld", 64'(bus.data_in_todb[2*h + int'(exp_sel)]), 64'(pld_of(h, exp_idx[h])));
          $display("txn stream hash%0d ch%0d beat %0d", h, 2*h + int'(exp_sel), exp_idx[h]);
          exp_idx[h]++;
          beats_out++;
        end
      end
      check("stream_rdy", 64'(bus.wdb_data_in_rdy), 64'hF);
      if (c < 16) begin
        for (int h = 0; h < NH; h++) begin
          hh = h ^ c;
          bus.wdb_data_in_vld[h]    = 1'b1;
          bus.wdb_data_in_ch_sel[h] = hh[0];
          bus.wdb_data_in[h]        = pld_of(h, c);
        end
      end else begin
        clear_inputs();
      end
      @(negedge clk);
    end
    check("stream_total", 64'(beats_out), 64'd64);
    for (int h = 0; h < NH; h++) check("stream_per_hash", 64'(exp_idx[h]), 64'd16);

    // 5. full FIFO on hash 2: push attempt and pop in the same cycle
    bus.data_in_rdy_fromdb    = '0;
    bus.wdb_data_in_vld[2]    = 1'b1;
    bus.wdb_data_in_ch_sel[2] = 1'b0;
    bus.wdb_data_in[2]        = 32'h20;
    @(negedge clk);
    bus.wdb_data_in_ch_sel[2] = 1'b1;
    bus.wdb_data_in[2]        = 32'h21;
    @(negedge clk);
    check("t5_full_rdy", 64'(bus.wdb_data_in_rdy[2]), 64'h0);
    bus.wdb_data_in_ch_sel[2] = 1'b0;
    bus.wdb_data_in[2]        = 32'h22;
    bus.data_in_rdy_fromdb[4] = 1'b1;
    @(negedge clk);
    $display("txn hash2 ch4 beat 20 with refused push");
    clear_inputs();
    check("t5_rdy_next", 64'(bus.wdb_data_in_rdy[2]), 64'h1);
    check("t5_vld_ch5", 64'(bus.data_in_vld_todb[5:4]), 64'h2);
    check("t5_pld_ch5", 64'(bus.data_in_todb[5]), 64'h21);
    bus.data_in_rdy_fromdb[5:4] = 2'b11;
    @(negedge clk);
    $display("txn hash2 ch5 beat 21");
    check("t5_refused_absent", 64'(bus.data_in_vld_todb), 64'h0);
    check("t5_pld_hold", 64'(bus.data_in_todb[4]), 64'h21);

    // 6. reset with beats buffered in hashes 2 and 3
    bus.data_in_rdy_fromdb = '0;
    bus.wdb_data_in_vld    = 4'b1100;
    bus.wdb_data_in[2]     = 32'h31;
    bus.wdb_data_in[3]     = 32'h41;
    @(negedge clk);
    bus.wdb_data_in[2]     = 32'h32;
    bus.wdb_data_in[3]     = 32'h42;
    @(negedge clk);
    clear_inputs();
    check("t6_buffered", 64'(bus.data_in_vld_todb), 64'h50);
    #2 rst = 1'b1;
    #1;
    check("t6_async_vld", 64'(bus.data_in_vld_todb), 64'h0);
    check("t6_async_pld", 64'(bus.data_in_todb[4]), 64'h0);
    check("t6_async_rdy", 64'(bus.wdb_data_in_rdy), 64'h0);
    check("t6_async_idle", 64'(bus.dispatch_idle), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    bus.data_in_rdy_fromdb = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t6_no_stale", 64'(bus.data_in_vld_todb), 64'h0);
      check("t6_idle", 64'(bus.dispatch_idle), 64'h1);
    end
    check("t6_rdy", 64'(bus.wdb_data_in_rdy), 64'hF);
    $display("txn reset with buffered beats done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
